// File: rtl/imem_loader.sv
// Boot loader: turns a byte stream (LE word count N, then N LE words) into
// instruction-memory writes. Write strobe follows a word's 4th byte by 1 cycle.
// Backpressure: in_ready is high only in LEN/DATA; bytes offered otherwise wait.
//
// Ports:
//   clk       - single clock, all state changes on the rising edge
//   rst       - synchronous active-low reset
//   start     - one-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_valid  - byte-stream valid
//   in_data   - stream byte
//   in_ready  - byte accepted when in_valid && in_ready at a rising edge
//   wr_en     - instruction memory write strobe (WRITE state only)
//   wr_addr   - word-aligned byte address, BASE_ADDR + 4*k
//   wr_data   - assembled instruction word
//   cpu_hold  - keeps the CPU in reset until a load completes
//   done      - load completed
//   err       - load rejected (word count exceeds IMEM_DEPTH)

module imem_loader #(
  parameter int          IMEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  byte_cnt;    // bytes accepted in the current 4-byte group
  logic [31:0] word_idx;    // 0-based index k of the word being assembled
  logic [31:0] word_total;  // N, latched at the end of the length field
  logic [31:0] partial;     // bytes enter at the top and shift right

  logic        accept;
  logic        last_byte;
  logic [31:0] assembled;
  logic        restart;

  // Little-endian assembly: shifting right means the first byte received
  // ends up in bits [7:0] once all four have arrived.
  assign assembled = {in_data, partial[31:8]};

  assign in_ready  = (state == LEN) || (state == DATA);
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign restart   = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  assign cpu_hold  = (state != DONE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic and write strobe
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;

    case (state)
      IDLE: begin
        if (start) state_nxt = LEN;
      end

      LEN: begin
        if (last_byte) begin
          if (assembled == 32'd0) begin
            state_nxt = DONE;
          end else if (assembled > DEPTH_W) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
          end
        end
      end

      DATA: begin
        if (last_byte) state_nxt = WRITE;
      end

      WRITE: begin
        wr_en = 1'b1;
        if ((word_idx + 32'd1) == word_total) begin
          state_nxt = DONE;
        end else begin
          state_nxt = DATA;
        end
      end

      DONE, ERR: begin
        if (start) state_nxt = LEN;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: byte/word counters, partial word, write address/data
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt   <= 2'd0;
      word_idx   <= 32'd0;
      word_total <= 32'd0;
      partial    <= 32'd0;
      wr_addr    <= 32'd0;
      wr_data    <= 32'd0;
    end else begin
      if (restart) begin
        byte_cnt   <= 2'd0;
        word_idx   <= 32'd0;
        word_total <= 32'd0;
        partial    <= 32'd0;
      end

      // The 2-bit counter wraps to 0 on the 4th byte, which leaves it
      // cleared for the next group without an explicit reset.
      if (accept) begin
        partial  <= assembled;
        byte_cnt <= byte_cnt + 2'd1;
      end

      if ((state == LEN) && last_byte) begin
        word_total <= assembled;
      end

      // Address and data are captured with the word's last byte so they
      // are already valid during the single WRITE cycle, and then hold.
      if ((state == DATA) && last_byte) begin
        wr_addr <= BASE_ADDR + {word_idx[29:0], 2'b00};
        wr_data <= assembled;
      end

      if (state == WRITE) begin
        word_idx <= word_idx + 32'd1;
        byte_cnt <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: byte-stream driver, write scoreboard, directed loads.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  imem_loader #(.IMEM_DEPTH(1024), .BASE_ADDR(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [31:0] last_addr = 32'hFFFF_FFFF;

  // expected writes: {addr, data}
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      last_addr = wr_addr;
      check("wr_in_ready_low", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[63:32]);
        check("wr_data", wr_data, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; returns on the negedge after it
  // was accepted, with in_valid dropped.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int base_cnt;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_wr_en",    {31'd0, wr_en},    32'd0);
    check("rst_wr_addr",  wr_addr,           32'd0);
    check("rst_wr_data",  wr_data,           32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic two-word load
    pulse_start();
    check("len_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h0010_0093});
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    wait_done("basic_done");
    check("basic_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("basic_wr_cnt", wr_cnt, 32'd2);
    check("basic_q_empty", exp_q.size(), 32'd0);

    // Empty load: DONE right after the 4th length byte
    pulse_start();
    check("restart_done_clr", {31'd0, done}, 32'd0);
    check("restart_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    send_word(32'd0, 0);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_wr_cnt", wr_cnt, 32'd2);

    // Overflow: N = 1025
    pulse_start();
    send_word(32'd1025, 0);
    check("ovf_err",      {31'd0, err},      32'd1);
    check("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    check("ovf_done",     {31'd0, done},     32'd0);
    check("ovf_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("ovf_wr_cnt",   wr_cnt,            32'd2);
    pulse_start();
    check("ovf_restart_err", {31'd0, err}, 32'd0);
    check("ovf_restart_rdy", {31'd0, in_ready}, 32'd1);
    send_word(32'd0, 0);
    check("ovf_recover_done", {31'd0, done}, 32'd1);

    // Stalled stream, N=1, gaps of 3 idle cycles, in_valid held during WRITE
    pulse_start();
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    send_word(32'd1, 0);
    send_word(32'hDEAD_BEEF, 3);
    check("stall_wr_en_now", {31'd0, wr_en}, 32'd1);
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_done", {31'd0, done}, 32'd1);
    check("stall_wr_cnt", wr_cnt, 32'd3);
    check("stall_q_empty", exp_q.size(), 32'd0);

    // Reset mid-word, with start and in_valid also asserted
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("midrst_wr_en",    {31'd0, wr_en},    32'd0);
    check("midrst_done",     {31'd0, done},     32'd0);
    check("midrst_wr_addr",  wr_addr,           32'd0);
    @(negedge clk);
    check("midrst_wr_en2", {31'd0, wr_en}, 32'd0);
    check("midrst_wr_cnt", wr_cnt, 32'd3);
    pulse_start();
    exp_q.push_back({32'h0, 32'hCAFE_F00D});
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    wait_done("fresh_done");
    check("fresh_wr_cnt", wr_cnt, 32'd4);

    // Full depth: 1024 incrementing words
    base_cnt = wr_cnt;
    pulse_start();
    send_word(32'd1024, 0);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = 32'h1000_0000 + 32'(i);
      exp_q.push_back({32'(4 * i), w});
      send_word(w, 0);
    end
    wait_done("full_done");
    check("full_wr_cnt", wr_cnt - base_cnt, 32'd1024);
    check("full_last_addr", last_addr, 32'h0000_0FFC);
    check("full_q_empty", exp_q.size(), 32'd0);
    check("full_err", {31'd0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 1024, instruction memory capacity in 32-bit words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, byte address of first written word.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset (rst==0 at a rising edge resets the block).
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a load.
REQ-006 SHALL have port in_valid, input, 1, byte-stream valid.
REQ-007 SHALL have port in_data, input, 8, stream byte.
REQ-008 SHALL have port in_ready, output, 1, byte accepted when in_valid && in_ready at a rising edge.
REQ-009 SHALL have port wr_en, output, 1, instruction memory write strobe.
REQ-010 SHALL have port wr_addr, output, 32, word-aligned byte address.
REQ-011 SHALL have port wr_data, output, 32, instruction word.
REQ-012 SHALL have port cpu_hold, output, 1, holds the CPU in reset while high.
REQ-013 SHALL have port done, output, 1, load complete.
REQ-014 SHALL have port err, output, 1, load rejected.

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-016 Stream format SHALL be: 4-byte little-endian word count N, then N words of 4 bytes each, little-endian (first byte -> bits [7:0]).
REQ-017 IDLE: in_ready=0; start=1 -> LEN, clear byte counter, word counter, partial word.
REQ-018 LEN: in_ready=1; after 4th accepted byte, N==0 -> DONE; N>IMEM_DEPTH -> ERR; else -> DATA.
REQ-019 DATA: in_ready=1; accepted bytes shift into partial word; on 4th byte -> WRITE.
REQ-020 WRITE: exactly one cycle; wr_en=1, in_ready=0, wr_addr=BASE_ADDR+4*k (k = 0-based word index), wr_data=assembled word.
REQ-021 After WRITE: k+1==N -> DONE, else -> DATA with byte counter cleared.
REQ-022 Latency: wr_en SHALL assert on the cycle immediately following acceptance of a word's 4th byte.
REQ-023 in_valid while in_ready==0 SHALL be ignored; no byte consumed; in_valid gaps of any length SHALL be tolerated.
REQ-024 wr_en SHALL be 0 in every state except WRITE; wr_addr/wr_data hold last values otherwise.
REQ-025 cpu_hold SHALL be 1 in IDLE, LEN, DATA, WRITE, ERR; 0 only in DONE.
REQ-026 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-027 start in LEN, DATA or WRITE SHALL be ignored.
REQ-028 start in DONE or ERR SHALL go to LEN, clearing done/err and re-asserting cpu_hold next cycle.
REQ-029 N==IMEM_DEPTH SHALL be accepted; last wr_addr = BASE_ADDR+4*(IMEM_DEPTH-1).
REQ-030 Word counter SHALL be 32 bits wide; N compared as unsigned 32-bit.

Reset
REQ-031 On rst==0 at a rising edge: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, err=0, counters and partial word cleared.
REQ-032 Reset mid-load SHALL discard the partial word; no wr_en in the cycle after reset.
REQ-033 Reset SHALL take priority over start and in_valid in the same cycle.

Verification
REQ-034 Basic: rst, start, bytes 02 00 00 00 13 00 00 00 93 00 10 00 -> wr_en at 0x0 data 32'h00000013, at 0x4 data 32'h00100093; done=1, cpu_hold=0.
REQ-035 Empty: start, N bytes 00 00 00 00 -> no wr_en, DONE one cycle after 4th byte.
REQ-036 Overflow: IMEM_DEPTH=1024, N=1025 (01 04 00 00) -> ERR, err=1, in_ready=0, no wr_en; later start -> LEN, err=0.
REQ-037 Stalled stream: N=1, word bytes separated by 3 idle cycles each, in_valid asserted during WRITE -> single write of correct word, no byte lost or duplicated.
REQ-038 Reset mid-word: N=2, reset after 2 bytes of word 1 -> IDLE, wr_en stays 0, cpu_hold=1; fresh load succeeds from address 0x0.
REQ-039 Full depth: N=1024 incrementing words -> 1024 writes, last at 0xFFC, done=1.
